// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm sweep checker and the lab logic blocks it verifies.
package minterm_pkg;

    localparam int unsigned N_VARS     = 4;
    localparam int unsigned N_MINTERMS = 16;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } sweep_state_t;

    // Lab 1: F = sum m(1,3,5,7,9) + d(6,12,13), minimised to A'D + C'D
    localparam logic [N_MINTERMS-1:0] LAB1_ON_MASK = 16'h02AA;
    localparam logic [N_MINTERMS-1:0] LAB1_DC_MASK = 16'h3040;

endpackage

// File: rtl/minterm_sweep_checker.sv
// Drives all 16 minterms onto a 4-input combinational block, captures its response
// and compares it against an ON-set with don't-care minterms masked out.
module minterm_sweep_checker
    import minterm_pkg::*;
#(
    parameter logic [N_MINTERMS-1:0] ON_MASK = LAB1_ON_MASK,
    parameter logic [N_MINTERMS-1:0] DC_MASK = LAB1_DC_MASK,
    parameter int unsigned           SETTLE  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_VARS-1:0]     abcd,
    input  logic                  f,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_MINTERMS-1:0] truth_table,
    output logic [N_MINTERMS-1:0] mismatch,
    output logic [4:0]            err_count
);

    // Settle counter counts cycles already spent in SETTLE, starting at 1 on entry
    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    sweep_state_t          state_q, state_d;
    logic [N_VARS-1:0]     idx_q, idx_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [N_MINTERMS-1:0] tt_q, tt_d;
    logic [N_MINTERMS-1:0] mm_q, mm_d;
    logic [4:0]            err_q, err_d;
    logic                  pass_q, pass_d;
    logic                  miss;

    // Next-state and capture logic for the sweep sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        err_d   = err_q;
        pass_d  = pass_q;
        miss    = (f ^ ON_MASK[idx_q]) & ~DC_MASK[idx_q];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    cnt_d   = 4'd1;
                    tt_d    = '0;
                    mm_d    = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleCnt) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                tt_d[idx_q] = f;
                if (miss) begin
                    mm_d[idx_q] = 1'b1;
                    err_d       = err_q + 5'd1;
                end
                if (idx_q == 4'(N_MINTERMS - 1)) begin
                    state_d = StDone;
                    // Resolve pass on entry to DONE so it is already valid alongside done
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = StSettle;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign abcd        = idx_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign pass        = pass_q;
    assign truth_table = tt_q;
    assign mismatch    = mm_q;
    assign err_count   = err_q;

endmodule
